// File: rtl/ex_ret_addr_stack_if.sv
// rtl/ex_ret_addr_stack_if.sv - pipeline-side bundle for the return-address stack
interface ex_ret_addr_stack_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          stall_in;
    logic          flush_in;
    logic          call_in;
    logic          ret_in;
    logic [AW-1:0] PC_in;
    logic          clr_err_in;
    logic [AW-1:0] ret_addr_out;
    logic          ret_valid_out;
    logic          ret_err_out;
    logic          overflow_out;
    logic          underflow_out;
    logic [CW-1:0] count_out;

    modport master (
        output stall_in, flush_in, call_in, ret_in, PC_in, clr_err_in,
        input  ret_addr_out, ret_valid_out, ret_err_out, overflow_out, underflow_out, count_out
    );

    modport slave (
        input  stall_in, flush_in, call_in, ret_in, PC_in, clr_err_in,
        output ret_addr_out, ret_valid_out, ret_err_out, overflow_out, underflow_out, count_out
    );
endinterface

// File: rtl/ex_ret_addr_stack.sv
// rtl/ex_ret_addr_stack.sv - execute-stage circular return-address stack
module ex_ret_addr_stack #(
    parameter int DEPTH      = 8,
    parameter int AW         = 32,
    parameter int RET_OFFSET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ex_ret_addr_stack_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] ret_addr_q;
    logic          ret_valid_q;
    logic          ret_err_q;
    logic          overflow_q;
    logic          underflow_q;

    logic          active;
    logic          do_call;
    logic          do_ret;
    logic          empty;
    logic          full;
    logic          set_ov;
    logic          set_uf;
    logic [PW-1:0] wr_idx;
    logic [AW-1:0] push_addr;

    assign active    = !bus.stall_in && !bus.flush_in;
    assign do_call   = active && bus.call_in;
    assign do_ret    = active && bus.ret_in;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // A tail call on a full stack replaces the top, so nothing old is lost.
    assign set_ov    = do_call && full && !do_ret;
    assign set_uf    = do_ret && empty;
    assign wr_idx    = (do_ret && !empty) ? ptr : ptr + PW'(1);
    assign push_addr = bus.PC_in + AW'(RET_OFFSET);

    // Storage has no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_call) begin
            mem[wr_idx] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            count       <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            ret_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ret_valid_q <= 1'b0;
            ret_err_q   <= 1'b0;
            if (!bus.stall_in) begin
                overflow_q  <= set_ov | (overflow_q & ~bus.clr_err_in);
                underflow_q <= set_uf | (underflow_q & ~bus.clr_err_in);
                if (bus.flush_in) begin
                    ptr   <= '0;
                    count <= '0;
                end else begin
                    if (do_ret && !empty) begin
                        ret_addr_q  <= mem[ptr];
                        ret_valid_q <= 1'b1;
                    end
                    if (set_uf) begin
                        ret_err_q <= 1'b1;
                    end
                    case ({bus.call_in, bus.ret_in})
                        2'b10: begin
                            ptr <= ptr + PW'(1);
                            if (!full) begin
                                count <= count + CW'(1);
                            end
                        end
                        2'b01: begin
                            if (!empty) begin
                                ptr   <= ptr - PW'(1);
                                count <= count - CW'(1);
                            end
                        end
                        2'b11: begin
                            // Underflowing tail call still pushes its return address.
                            if (empty) begin
                                ptr   <= ptr + PW'(1);
                                count <= CW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.ret_addr_out  = ret_addr_q;
    assign bus.ret_valid_out = ret_valid_q;
    assign bus.ret_err_out   = ret_err_q;
    assign bus.overflow_out  = overflow_q;
    assign bus.underflow_out = underflow_q;
    assign bus.count_out     = count;
endmodule

// File: tb/tb_ex_ret_addr_stack.sv
// tb/tb_ex_ret_addr_stack.sv - directed self-checking bench for ex_ret_addr_stack
module tb_ex_ret_addr_stack;
    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    ex_ret_addr_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    ex_ret_addr_stack #(.DEPTH(DEPTH), .AW(AW), .RET_OFFSET(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.stall_in   = 1'b0;
        bus.flush_in   = 1'b0;
        bus.call_in    = 1'b0;
        bus.ret_in     = 1'b0;
        bus.PC_in      = '0;
        bus.clr_err_in = 1'b0;
    endtask

    // Apply one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic cyc(input logic stall, input logic flush, input logic call,
                       input logic ret, input logic [AW-1:0] pc, input logic clr);
        bus.stall_in   = stall;
        bus.flush_in   = flush;
        bus.call_in    = call;
        bus.ret_in     = ret;
        bus.PC_in      = pc;
        bus.clr_err_in = clr;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (bus.count_out !== 4'd0) begin fails++; $display("FAIL reset_count act=%0d exp=0", bus.count_out); end
        checks++; if ({bus.ret_valid_out, bus.ret_err_out, bus.overflow_out, bus.underflow_out} !== 4'b0000) begin fails++; $display("FAIL reset_flags act=%b exp=0000", {bus.ret_valid_out, bus.ret_err_out, bus.overflow_out, bus.underflow_out}); end
        checks++; if (bus.ret_addr_out !== 32'h0) begin fails++; $display("FAIL reset_addr act=%h exp=0", bus.ret_addr_out); end
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_addr [3];
        exp_addr[0] = 32'h31; exp_addr[1] = 32'h21; exp_addr[2] = 32'h11;
        cyc(0, 0, 1, 0, 32'h10, 0);
        cyc(0, 0, 1, 0, 32'h20, 0);
        cyc(0, 0, 1, 0, 32'h30, 0);
        checks++; if (bus.count_out !== 4'd3) begin fails++; $display("FAIL basic_count3 act=%0d exp=3", bus.count_out); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, '0, 0);
            checks++; if (bus.ret_addr_out !== exp_addr[i] || bus.ret_valid_out !== 1'b1) begin fails++; $display("FAIL basic_ret%0d act=%h/%b exp=%h/1", i, bus.ret_addr_out, bus.ret_valid_out, exp_addr[i]); end
            checks++; if (bus.count_out !== 4'(2 - i)) begin fails++; $display("FAIL basic_cnt%0d act=%0d exp=%0d", i, bus.count_out, 2 - i); end
        end
        cyc(0, 0, 0, 0, '0, 0);
        checks++; if (bus.ret_valid_out !== 1'b0 || bus.ret_addr_out !== 32'h11) begin fails++; $display("FAIL basic_idle act=%b/%h exp=0/11", bus.ret_valid_out, bus.ret_addr_out); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 1, 0, AW'(i), 0);
        checks++; if (bus.count_out !== 4'd8 || bus.overflow_out !== 1'b1) begin fails++; $display("FAIL ovf_state act=%0d/%b exp=8/1", bus.count_out, bus.overflow_out); end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 1, '0, 0);
            checks++; if (bus.ret_addr_out !== AW'(9 - i) || bus.ret_valid_out !== 1'b1) begin fails++; $display("FAIL ovf_ret%0d act=%h/%b exp=%h/1", i, bus.ret_addr_out, bus.ret_valid_out, 9 - i); end
        end
        cyc(0, 0, 0, 1, '0, 0);
        checks++; if (bus.ret_err_out !== 1'b1 || bus.underflow_out !== 1'b1 || bus.ret_valid_out !== 1'b0) begin fails++; $display("FAIL ovf_underflow act=%b%b%b exp=110", bus.ret_err_out, bus.underflow_out, bus.ret_valid_out); end
        checks++; if (bus.ret_addr_out !== 32'h2 || bus.count_out !== 4'd0) begin fails++; $display("FAIL ovf_hold act=%h/%0d exp=2/0", bus.ret_addr_out, bus.count_out); end
        cyc(0, 0, 0, 0, '0, 1);
        checks++; if (bus.overflow_out !== 1'b0 || bus.underflow_out !== 1'b0 || bus.ret_err_out !== 1'b0) begin fails++; $display("FAIL ovf_clr act=%b%b%b exp=000", bus.overflow_out, bus.underflow_out, bus.ret_err_out); end
    endtask

    task automatic test_tail_call();
        cyc(0, 0, 1, 0, 32'h40, 0);
        checks++; if (bus.count_out !== 4'd1) begin fails++; $display("FAIL tail_cnt_a act=%0d exp=1", bus.count_out); end
        cyc(0, 0, 1, 1, 32'h50, 0);
        checks++; if (bus.ret_addr_out !== 32'h41 || bus.ret_valid_out !== 1'b1 || bus.count_out !== 4'd1) begin fails++; $display("FAIL tail_swap act=%h/%b/%0d exp=41/1/1", bus.ret_addr_out, bus.ret_valid_out, bus.count_out); end
        cyc(0, 0, 0, 1, '0, 0);
        checks++; if (bus.ret_addr_out !== 32'h51 || bus.ret_valid_out !== 1'b1 || bus.count_out !== 4'd0) begin fails++; $display("FAIL tail_pop act=%h/%b/%0d exp=51/1/0", bus.ret_addr_out, bus.ret_valid_out, bus.count_out); end
    endtask

    task automatic test_stall_flush();
        cyc(0, 0, 1, 0, 32'h60, 0);
        cyc(0, 0, 1, 0, 32'h70, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1, '0, 0);
            checks++; if (bus.ret_valid_out !== 1'b0 || bus.ret_err_out !== 1'b0 || bus.count_out !== 4'd2) begin fails++; $display("FAIL stall%0d act=%b%b/%0d exp=00/2", i, bus.ret_valid_out, bus.ret_err_out, bus.count_out); end
        end
        cyc(0, 1, 0, 0, '0, 0);
        checks++; if (bus.count_out !== 4'd0) begin fails++; $display("FAIL flush_cnt act=%0d exp=0", bus.count_out); end
        cyc(0, 0, 0, 1, '0, 0);
        checks++; if (bus.ret_err_out !== 1'b1 || bus.ret_valid_out !== 1'b0 || bus.ret_addr_out !== 32'h51) begin fails++; $display("FAIL flush_ret act=%b%b/%h exp=10/51", bus.ret_err_out, bus.ret_valid_out, bus.ret_addr_out); end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 1, 0, 32'h80, 0);
        cyc(0, 0, 1, 0, 32'h90, 0);
        cyc(0, 0, 1, 0, 32'hA0, 0);
        checks++; if (bus.count_out !== 4'd3 || bus.underflow_out !== 1'b1) begin fails++; $display("FAIL arst_pre act=%0d/%b exp=3/1", bus.count_out, bus.underflow_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.count_out !== 4'd0 || bus.underflow_out !== 1'b0 || bus.ret_addr_out !== 32'h0) begin fails++; $display("FAIL arst_now act=%0d/%b/%h exp=0/0/0", bus.count_out, bus.underflow_out, bus.ret_addr_out); end
        #2;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 1, '0, 0);
        checks++; if (bus.ret_err_out !== 1'b1 || bus.underflow_out !== 1'b1 || bus.ret_valid_out !== 1'b0) begin fails++; $display("FAIL arst_ret act=%b%b%b exp=110", bus.ret_err_out, bus.underflow_out, bus.ret_valid_out); end
    endtask

    task automatic test_clr_err();
        cyc(0, 0, 0, 0, '0, 1);
        checks++; if (bus.underflow_out !== 1'b0) begin fails++; $display("FAIL clr_only act=%b exp=0", bus.underflow_out); end
        cyc(0, 0, 0, 1, '0, 1);
        checks++; if (bus.underflow_out !== 1'b1 || bus.ret_err_out !== 1'b1) begin fails++; $display("FAIL clr_vs_set act=%b%b exp=11", bus.underflow_out, bus.ret_err_out); end
        cyc(0, 0, 1, 1, 32'hC0, 1);
        checks++; if (bus.ret_err_out !== 1'b1 || bus.count_out !== 4'd1 || bus.underflow_out !== 1'b1) begin fails++; $display("FAIL tail_empty act=%b/%0d/%b exp=1/1/1", bus.ret_err_out, bus.count_out, bus.underflow_out); end
        cyc(0, 0, 0, 1, '0, 0);
        checks++; if (bus.ret_addr_out !== 32'hC1 || bus.ret_valid_out !== 1'b1 || bus.count_out !== 4'd0) begin fails++; $display("FAIL tail_empty_pop act=%h/%b/%0d exp=c1/1/0", bus.ret_addr_out, bus.ret_valid_out, bus.count_out); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_tail_call();
        test_stall_flush();
        test_async_reset();
        test_clr_err();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
